// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its address checker.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } st_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DM_WORDS_DEF = 3072;

endpackage

// File: rtl/dm_addr_check.sv
// Combinational legality check of a DM byte address: word aligned, inside the
// populated word range, and with no bits set above the 16KB window.
module dm_addr_check
    import dm_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DM_WORDS = DM_WORDS_DEF
) (
    input  logic [DATA_W-1:0] i_addr,
    output logic              o_ok
);

    localparam logic [12:0] WORDS_LIM = 13'(DM_WORDS);

    logic [11:0] w_word;

    assign w_word = i_addr[13:2];
    assign o_ok   = (i_addr[1:0] == 2'b00)
                 && ({1'b0, w_word} < WORDS_LIM)
                 && (i_addr[DATA_W-1:14] == '0);

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port data memory
// between the CPU load/store port (C) and the debug/DMA port (D).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DM_WORDS  = DM_WORDS_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [DATA_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wd,
    input  logic [DATA_W-1:0] c_pc,
    output logic              c_ack,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rd,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wd,
    input  logic [DATA_W-1:0] d_pc,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rd,
    output logic [DATA_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_WD,
    output logic [DATA_W-1:0] mem_PC,
    input  logic [DATA_W-1:0] mem_RD
);

    localparam int               CNT_W   = $clog2(BURST_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(BURST_MAX - 1);

    st_t              r_st, w_st_nxt;
    logic             r_last, w_last_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_c_ok, w_d_ok;
    logic             w_own_vld, w_own, w_err;

    dm_addr_check #(.DATA_W(DATA_W), .DM_WORDS(DM_WORDS)) u_chk_c (
        .i_addr (c_addr),
        .o_ok   (w_c_ok)
    );

    dm_addr_check #(.DATA_W(DATA_W), .DM_WORDS(DM_WORDS)) u_chk_d (
        .i_addr (d_addr),
        .o_ok   (w_d_ok)
    );

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_own_vld = 1'b0;
        w_own     = PORT_C;
        case (r_st)
            OWN_C: begin
                if (c_req && ((r_cnt < CNT_LIM) || !d_req)) begin
                    w_own_vld = 1'b1;
                    w_own     = PORT_C;
                end else if (d_req) begin
                    w_own_vld = 1'b1;
                    w_own     = PORT_D;
                end
            end
            OWN_D: begin
                if (d_req && ((r_cnt < CNT_LIM) || !c_req)) begin
                    w_own_vld = 1'b1;
                    w_own     = PORT_D;
                end else if (c_req) begin
                    w_own_vld = 1'b1;
                    w_own     = PORT_C;
                end
            end
            default: begin
                // A tie from idle goes to whichever port was not served last.
                if (c_req && d_req) begin
                    w_own_vld = 1'b1;
                    w_own     = ~r_last;
                end else if (c_req) begin
                    w_own_vld = 1'b1;
                    w_own     = PORT_C;
                end else if (d_req) begin
                    w_own_vld = 1'b1;
                    w_own     = PORT_D;
                end
            end
        endcase
        if (!reset) begin
            w_own_vld = 1'b0;
        end
    end

    always_comb begin
        w_st_nxt   = IDLE;
        w_last_nxt = r_last;
        w_cnt_nxt  = '0;
        if (w_own_vld) begin
            w_st_nxt   = (w_own == PORT_D) ? OWN_D : OWN_C;
            w_last_nxt = w_own;
            if (w_st_nxt == r_st) begin
                w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_st   <= IDLE;
            r_last <= PORT_D;
            r_cnt  <= '0;
        end else begin
            r_st   <= w_st_nxt;
            r_last <= w_last_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign w_err = (w_own == PORT_D) ? !w_d_ok : !w_c_ok;

    always_comb begin
        mem_A  = '0;
        mem_WD = '0;
        mem_PC = '0;
        mem_WE = 1'b0;
        c_ack  = 1'b0;
        c_err  = 1'b0;
        c_rd   = '0;
        d_ack  = 1'b0;
        d_err  = 1'b0;
        d_rd   = '0;
        if (w_own_vld) begin
            if (w_own == PORT_C) begin
                mem_A  = c_addr;
                mem_WD = c_wd;
                mem_PC = c_pc;
                mem_WE = c_we && !w_err;
                c_ack  = 1'b1;
                c_err  = w_err;
                c_rd   = w_err ? '0 : mem_RD;
            end else begin
                mem_A  = d_addr;
                mem_WD = d_wd;
                mem_PC = d_pc;
                mem_WE = d_we && !w_err;
                d_ack  = 1'b1;
                d_err  = w_err;
                d_rd   = w_err ? '0 : mem_RD;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a behavioural DM behind the arbiter,
// table-driven vectors plus burst/saturation sequences through a scoreboard.
module tb_dm_arbiter;

    typedef struct {
        string       name;
        bit          rst;
        bit          cr;
        bit          cw;
        logic [31:0] ca;
        logic [31:0] cwd;
        bit          dr;
        bit          dw;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          e_cack;
        bit          e_dack;
        bit          e_err;
        bit          e_we;
        logic [31:0] e_rd;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wd, c_pc, d_addr, d_wd, d_pc;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rd, d_rd;
    logic [31:0] mem_A, mem_WD, mem_PC, mem_RD;
    logic        mem_WE;

    logic [31:0] dm [0:3071];
    logic [11:0] w_idx;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t m_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    dm_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .c_req  (c_req),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_wd   (c_wd),
        .c_pc   (c_pc),
        .c_ack  (c_ack),
        .c_err  (c_err),
        .c_rd   (c_rd),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wd   (d_wd),
        .d_pc   (d_pc),
        .d_ack  (d_ack),
        .d_err  (d_err),
        .d_rd   (d_rd),
        .mem_A  (mem_A),
        .mem_WE (mem_WE),
        .mem_WD (mem_WD),
        .mem_PC (mem_PC),
        .mem_RD (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at the closing edge.
    assign w_idx  = mem_A[13:2];
    assign mem_RD = (w_idx < 12'd3072) ? dm[w_idx] : 32'h0;

    initial begin
        for (int i = 0; i < 3072; i++) dm[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_WE && (w_idx < 12'd3072)) dm[w_idx] <= mem_WD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit rst,
                                input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cwd,
                                input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                                input bit ecack, input bit edack, input bit eerr, input bit ewe,
                                input logic [31:0] erd);
        vec_t v;
        v.name = n;   v.rst = rst;
        v.cr = cr;    v.cw = cw;    v.ca = ca;    v.cwd = cwd;
        v.dr = dr;    v.dw = dw;    v.da = da;    v.dwd = dwd;
        v.e_cack = ecack; v.e_dack = edack; v.e_err = eerr; v.e_we = ewe; v.e_rd = erd;
        return v;
    endfunction

    task automatic run(input vec_t v);
        reset  = v.rst;
        c_req  = v.cr;  c_we = v.cw;  c_addr = v.ca;  c_wd = v.cwd;  c_pc = 32'h0040_0000 | v.ca;
        d_req  = v.dr;  d_we = v.dw;  d_addr = v.da;  d_wd = v.dwd;  d_pc = 32'h0080_0000 | v.da;
        sb.push_back(v);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop the expectation for the cycle in flight and compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            check({m_e.name, " c_ack"}, 32'(c_ack), 32'(m_e.e_cack));
            check({m_e.name, " d_ack"}, 32'(d_ack), 32'(m_e.e_dack));
            check({m_e.name, " c_err"}, 32'(c_err), 32'(m_e.e_cack & m_e.e_err));
            check({m_e.name, " d_err"}, 32'(d_err), 32'(m_e.e_dack & m_e.e_err));
            check({m_e.name, " mem_WE"}, 32'(mem_WE), 32'(m_e.e_we));
            if (m_e.rst) begin
                check({m_e.name, " mem_A"}, mem_A,
                      m_e.e_cack ? m_e.ca : (m_e.e_dack ? m_e.da : 32'h0));
                check({m_e.name, " mem_WD"}, mem_WD,
                      m_e.e_cack ? m_e.cwd : (m_e.e_dack ? m_e.dwd : 32'h0));
                check({m_e.name, " mem_PC"}, mem_PC,
                      m_e.e_cack ? (32'h0040_0000 | m_e.ca) :
                      (m_e.e_dack ? (32'h0080_0000 | m_e.da) : 32'h0));
            end
            if (!(m_e.e_cack && m_e.cw))
                check({m_e.name, " c_rd"}, c_rd, m_e.e_cack ? m_e.e_rd : 32'h0);
            if (!(m_e.e_dack && m_e.dw))
                check({m_e.name, " d_rd"}, d_rd, m_e.e_dack ? m_e.e_rd : 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0; c_pc = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0; d_pc = '0;

        //                  name          rst  cr cw ca          cwd            dr dw da          dwd            cak dak err we  rd
        tbl.push_back(mk("rst_hold",    0,   1, 0, 32'h10,     32'h0,         1, 0, 32'h20,     32'h0,         0,  0,  0,  0,  32'h0));
        tbl.push_back(mk("t1_wr",       1,   1, 1, 32'h10,     32'hDEADBEEF,  0, 0, 32'h0,      32'h0,         1,  0,  0,  1,  32'h0));
        tbl.push_back(mk("t1_rd",       1,   1, 0, 32'h10,     32'h0,         0, 0, 32'h0,      32'h0,         1,  0,  0,  0,  32'hDEADBEEF));
        tbl.push_back(mk("t6_idle",     1,   0, 0, 32'h0,      32'h0,         0, 0, 32'h0,      32'h0,         0,  0,  0,  0,  32'h0));
        tbl.push_back(mk("t2_rst",      0,   1, 0, 32'h10,     32'h0,         1, 0, 32'h20,     32'h0,         0,  0,  0,  0,  32'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk($sformatf("t2_c%0d", i), 1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk("t2_dwr",      1,   1, 0, 32'h10,     32'h0,         1, 1, 32'h20,     32'h12345678,  0,  1,  0,  1,  32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("t2_d%0d", i), 1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0, 1, 0, 0, 32'h12345678));
        tbl.push_back(mk("t2_cret",     1,   1, 0, 32'h10,     32'h0,         1, 0, 32'h20,     32'h0,         1,  0,  0,  0,  32'hDEADBEEF));
        tbl.push_back(mk("t3_d",        1,   0, 0, 32'h0,      32'h0,         1, 0, 32'h20,     32'h0,         0,  1,  0,  0,  32'h12345678));
        tbl.push_back(mk("t3_d2",       1,   1, 0, 32'h10,     32'h0,         1, 0, 32'h20,     32'h0,         0,  1,  0,  0,  32'h12345678));
        tbl.push_back(mk("t3_drop",     1,   1, 0, 32'h10,     32'h0,         0, 0, 32'h0,      32'h0,         1,  0,  0,  0,  32'hDEADBEEF));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("t3_c%0d", i), 1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk("t3_dback",    1,   1, 0, 32'h10,     32'h0,         1, 0, 32'h20,     32'h0,         0,  1,  0,  0,  32'h12345678));
        tbl.push_back(mk("t4_oor",      1,   1, 1, 32'h3000,   32'hBAD0BAD0,  0, 0, 32'h0,      32'h0,         1,  0,  1,  0,  32'h0));
        tbl.push_back(mk("t4_mis",      1,   1, 1, 32'h12,     32'hBAD1BAD1,  0, 0, 32'h0,      32'h0,         1,  0,  1,  0,  32'h0));
        tbl.push_back(mk("t4_rb",       1,   1, 0, 32'h10,     32'h0,         0, 0, 32'h0,      32'h0,         1,  0,  0,  0,  32'hDEADBEEF));
        tbl.push_back(mk("t4_hi",       1,   0, 0, 32'h0,      32'h0,         1, 0, 32'h4010,   32'h0,         0,  1,  1,  0,  32'h0));
        tbl.push_back(mk("t4_top_wr",   1,   0, 0, 32'h0,      32'h0,         1, 1, 32'h2FFC,   32'hCAFEF00D,  0,  1,  0,  1,  32'h0));
        tbl.push_back(mk("t4_top_rd",   1,   0, 0, 32'h0,      32'h0,         1, 0, 32'h2FFC,   32'h0,         0,  1,  0,  0,  32'hCAFEF00D));
        tbl.push_back(mk("t5_rst",      0,   1, 1, 32'h10,     32'h0BADC0DE,  1, 0, 32'h2FFC,   32'h0,         0,  0,  0,  0,  32'h0));
        tbl.push_back(mk("t5_tie",      1,   1, 0, 32'h10,     32'h0,         1, 0, 32'h2FFC,   32'h0,         1,  0,  0,  0,  32'hDEADBEEF));
        tbl.push_back(mk("t6_idle2",    1,   0, 0, 32'h0,      32'h0,         0, 0, 32'h0,      32'h0,         0,  0,  0,  0,  32'h0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) run(tbl[i]);

        // Both hold requests from idle with C served last: D,D,D,D,C,C,C,C,...
        for (int k = 0; k < 16; k++) begin
            run(mk($sformatf("alt%0d", k), 1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h2FFC, 32'h0,
                   ((k / 4) % 2) != 0, ((k / 4) % 2) == 0, 0, 0,
                   (((k / 4) % 2) == 0) ? 32'hCAFEF00D : 32'hDEADBEEF));
        end

        // C alone keeps the grant past the burst limit; the count must saturate,
        // so a late D request wins immediately.
        for (int k = 0; k < 5; k++)
            run(mk($sformatf("solo_c%0d", k), 1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF));
        run(mk("sat_switch", 1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h2FFC, 32'h0, 0, 1, 0, 0, 32'hCAFEF00D));

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
